// File: rtl/div16_progressive.sv
// Sequential signed restoring divider: Q1.30 dividend / Q0.15 divisor -> Q0.15 quotient,
// one quotient bit per cycle, with early Q0.3 and Q0.7 truncations of the running quotient.
module div16_progressive (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic [3:0]  q0_3_out,
    output logic        q0_3_valid,
    output logic [7:0]  q0_7_out,
    output logic        q0_7_valid,
    output logic [15:0] q0_15_out,
    output logic        q0_15_valid,
    output logic        overflow,
    output logic        div_by_zero
);

    // Handshake: a request is taken on any rising edge where valid_in && ready_out.
    // ready_out is high exactly while IDLE; valid_in in any other state is ignored,
    // and dividend/divisor are only looked at on the accepting edge.

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic [31:0] rem;
    logic [15:0] mag_d;
    logic [15:0] mag;
    logic [3:0]  cnt;
    logic        sign;
    logic        forced;
    logic        ovf_r;
    logic        dz_r;

    logic        accept;
    logic [31:0] mag_n_in;
    logic [15:0] mag_d_in;
    logic        sign_in;
    logic        dz_in;
    logic        ovf_in;
    logic [31:0] trial;
    logic        fits;

    assign accept   = valid_in && ready_out;
    assign mag_n_in = dividend[31] ? (~dividend + 32'd1) : dividend;
    assign mag_d_in = divisor[15] ? (~divisor + 16'd1) : divisor;
    assign sign_in  = dividend[31] ^ divisor[15];
    assign dz_in    = (divisor == 16'd0);
    // Quotient of 1.0 or more cannot be held in Q0.15; exact -1.0 is flagged too.
    assign ovf_in   = !dz_in && (mag_n_in >= {1'b0, mag_d_in, 15'd0});

    // Shifted divisor for the current bit position; at most 31 significant bits.
    assign trial = {16'd0, mag_d} << cnt;
    assign fits  = (rem >= trial);

    assign ready_out = (state == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = RUN;
            RUN:     if (cnt == 4'd0) state_nxt = OUT;
            OUT:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rem         <= 32'd0;
            mag_d       <= 16'd0;
            mag         <= 16'd0;
            cnt         <= 4'd0;
            sign        <= 1'b0;
            forced      <= 1'b0;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
            q0_3_out    <= 4'd0;
            q0_3_valid  <= 1'b0;
            q0_7_out    <= 8'd0;
            q0_7_valid  <= 1'b0;
            q0_15_out   <= 16'd0;
            q0_15_valid <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            q0_3_valid  <= 1'b0;
            q0_7_valid  <= 1'b0;
            q0_15_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        sign   <= sign_in;
                        forced <= dz_in || ovf_in;
                        ovf_r  <= ovf_in;
                        dz_r   <= dz_in;
                        rem    <= mag_n_in;
                        mag_d  <= mag_d_in;
                        cnt    <= 4'd15;
                        // For divide-by-zero sign_in equals the dividend sign, so one
                        // saturation rule covers both forced cases.
                        if (dz_in || ovf_in) begin
                            mag <= sign_in ? 16'h8000 : 16'h7FFF;
                        end else begin
                            mag <= 16'd0;
                        end
                    end
                end
                RUN: begin
                    if (!forced && fits) begin
                        rem      <= rem - trial;
                        mag[cnt] <= 1'b1;
                    end
                    cnt <= cnt - 4'd1;
                    // Upper bits are final once the step for the next lower bit runs.
                    if (cnt == 4'd11) begin
                        q0_3_out   <= sign ? (~mag[15:12] + 4'd1) : mag[15:12];
                        q0_3_valid <= 1'b1;
                    end
                    if (cnt == 4'd7) begin
                        q0_7_out   <= sign ? (~mag[15:8] + 8'd1) : mag[15:8];
                        q0_7_valid <= 1'b1;
                    end
                end
                OUT: begin
                    q0_15_out   <= sign ? (~mag + 16'd1) : mag;
                    q0_15_valid <= 1'b1;
                    overflow    <= ovf_r;
                    div_by_zero <= dz_r;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div16_progressive.sv
// Randomized and directed bench for div16_progressive against an arithmetic reference
// model; checks strobe timing cycle by cycle after every accepted request.
module tb_div16_progressive;

    logic        clk;
    logic        rst;
    logic        valid_in;
    logic        ready_out;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic [3:0]  q0_3_out;
    logic        q0_3_valid;
    logic [7:0]  q0_7_out;
    logic        q0_7_valid;
    logic [15:0] q0_15_out;
    logic        q0_15_valid;
    logic        overflow;
    logic        div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    div16_progressive dut (
        .clk         (clk),
        .rst         (rst),
        .valid_in    (valid_in),
        .ready_out   (ready_out),
        .dividend    (dividend),
        .divisor     (divisor),
        .q0_3_out    (q0_3_out),
        .q0_3_valid  (q0_3_valid),
        .q0_7_out    (q0_7_out),
        .q0_7_valid  (q0_7_valid),
        .q0_15_out   (q0_15_out),
        .q0_15_valid (q0_15_valid),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    // clock / watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division with saturation rules.
    task automatic model(input logic [31:0] n, input logic [15:0] d,
                         output logic [15:0] e15, output logic [7:0] e7,
                         output logic [3:0] e3, output logic eov, output logic edz);
        longint nn, dd, magn, magd, m;
        logic   s;
        nn  = longint'($signed(n));
        dd  = longint'($signed(d));
        s   = n[31] ^ d[15];
        eov = 1'b0;
        edz = 1'b0;
        if (dd == 0) begin
            edz = 1'b1;
            m   = (nn >= 0) ? 64'h7FFF : 64'h8000;
        end else begin
            magn = (nn < 0) ? -nn : nn;
            magd = (dd < 0) ? -dd : dd;
            if (magn >= magd * 32768) begin
                eov = 1'b1;
                m   = s ? 64'h8000 : 64'h7FFF;
            end else begin
                m = magn / magd;
            end
        end
        e15 = s ? 16'(-m)        : 16'(m);
        e7  = s ? 8'(-(m >> 8))  : 8'(m >> 8);
        e3  = s ? 4'(-(m >> 12)) : 4'(m >> 12);
    endtask

    // mode 0: normal, 1: busy request at T+3, 2: reset at T+7
    task automatic run_op(input logic [31:0] n, input logic [15:0] d, input int mode);
        logic [15:0] e15;
        logic [7:0]  e7;
        logic [3:0]  e3;
        logic        eov, edz;
        int          guard;
        model(n, d, e15, e7, e3, eov, edz);
        exp_q.push_back(e15);
        guard = 0;
        while (!ready_out && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        check("ready_wait", {31'd0, ready_out}, 32'd1);
        @(negedge clk);
        valid_in = 1'b1;
        dividend = n;
        divisor  = d;
        @(posedge clk); #1;
        valid_in = 1'b0;
        dividend = $urandom;
        divisor  = 16'($urandom);
        for (int k = 1; k <= 18; k++) begin
            if (mode == 1 && k == 3) begin
                valid_in = 1'b1;
                dividend = $urandom;
                divisor  = 16'h0001;
            end
            if (mode == 2 && k == 7) rst = 1'b1;
            @(posedge clk); #1;
            valid_in = 1'b0;
            rst      = 1'b0;
            if (mode == 2 && k >= 7) begin
                check("rst_flags", {28'd0, ready_out, q0_3_valid, q0_7_valid, q0_15_valid},
                      32'h8);
                if (k == 7)
                    check("rst_data", {2'd0, q0_3_out, q0_7_out, q0_15_out, overflow,
                                       div_by_zero}, 32'd0);
            end else begin
                check("flags", {28'd0, ready_out, q0_3_valid, q0_7_valid, q0_15_valid},
                      {28'd0, k >= 17, k == 5, k == 9, k == 17});
                if (k == 5) check("q0_3", {28'd0, q0_3_out}, {28'd0, e3});
                if (k == 9) check("q0_7", {24'd0, q0_7_out}, {24'd0, e7});
                if (k == 17) begin
                    check("q0_15", {16'd0, q0_15_out}, {16'd0, exp_q.pop_front()});
                    check("overflow", {31'd0, overflow}, {31'd0, eov});
                    check("div_by_zero", {31'd0, div_by_zero}, {31'd0, edz});
                end
            end
        end
        if (mode == 2) void'(exp_q.pop_back());
    endtask

    initial begin
        logic [31:0] rn;
        logic [15:0] rd;
        rst      = 1'b1;
        valid_in = 1'b0;
        dividend = 32'd0;
        divisor  = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready", {31'd0, ready_out}, 32'd1);
        check("reset_data", {2'd0, q0_3_out, q0_7_out, q0_15_out, overflow, div_by_zero},
              32'd0);
        check("reset_strobes", {29'd0, q0_3_valid, q0_7_valid, q0_15_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        run_op(32'h10000000, 16'h4000, 0);
        run_op(32'hF0000000, 16'h4000, 0);
        run_op(32'h20000000, 16'h4000, 0);
        run_op(32'hE0000000, 16'h4000, 0);
        run_op(32'h00001234, 16'h0000, 0);
        run_op(32'hFFFFEDCC, 16'h0000, 0);
        run_op(32'd100,      16'd3,    0);
        run_op(32'hFFFFFF9C, 16'd3,    0);
        run_op(32'h80000000, 16'h8000, 0);
        run_op(32'h1FFFFFFF, 16'h4000, 0);
        run_op(32'h00000000, 16'hC000, 0);
        run_op(32'h10000000, 16'h4000, 1);
        run_op(32'h10000000, 16'h4000, 2);
        run_op(32'hF0000000, 16'h4000, 0);

        for (int i = 0; i < 30; i++) begin
            rd = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rd = 16'd0;
            rn = 32'($signed($urandom) >>> $urandom_range(0, 20));
            run_op(rn, rd, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/div16_progressive.md
Name: div16_progressive

Overview:
- Sequential signed fixed-point divider; the inverse of the progressive 16x16 multiplier.
- Takes a Q1.30 dividend (product-domain value) and a Q0.15 divisor, and recovers the Q0.15 quotient.
- Radix-2 restoring division, one quotient bit per cycle, with progressive Q0.3, Q0.7 and Q0.15 results and one-cycle valid strobes.
- Sits after attention-score products to normalise them back to Q0.15.

Parameters:
- None. All widths are fixed by the Q formats.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- valid_in  input  1  request; accepted on an edge where valid_in && ready_out
- ready_out  output  1  high only in IDLE
- dividend  input  32  signed Q1.30
- divisor  input  16  signed Q0.15
- q0_3_out  output  4  signed Q0.3 early quotient
- q0_3_valid  output  1  one-cycle strobe
- q0_7_out  output  8  signed Q0.7 intermediate quotient
- q0_7_valid  output  1  one-cycle strobe
- q0_15_out  output  16  signed Q0.15 final quotient
- q0_15_valid  output  1  one-cycle strobe
- overflow  output  1  final result saturated; updated with q0_15_valid
- div_by_zero  output  1  divisor was 0; updated with q0_15_valid

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- Reset:
  - All outputs are 0 except ready_out=1.
  - State goes to IDLE.
  - Any in-flight operation is dropped and no strobes fire afterward.
  - Reset takes priority over acceptance on the same edge.
- Arithmetic:
  - Quotient integer Q = trunc(N/D), where N and D are the raw two's-complement integers. Truncation is toward zero.
  - sign = dividend[31] ^ divisor[15].
  - magN = |N| (32-bit unsigned, so -2^31 is handled). magD = |D| (16-bit unsigned).
- Special cases, decided at the accept edge:
  - D == 0: div_by_zero=1, overflow=0. Magnitude is forced to 0x7FFF if N>=0, else result is 0x8000.
  - magN >= magD<<15 (result not representable): overflow=1. Magnitude is saturated, giving result 0x7FFF if sign=0 and 0x8000 if sign=1. The flag stays set even for the exact -1.0 boundary case.
  - When forced, the iterations leave the quotient register untouched. Latency is unchanged.
- State machine IDLE -> RUN -> OUT -> IDLE. Accept edge = T.
  - IDLE: ready_out=1. On accept: latch sign and flags, remainder R=magN, cnt=15, go to RUN.
  - RUN (edges T+1..T+16): if R >= magD<<cnt then R -= magD<<cnt and mag[cnt]=1, else mag[cnt]=0. Decrement cnt. After the cnt=0 step, go to OUT.
  - OUT (edge T+17): register final outputs, go to IDLE. ready_out=1 from cycle after T+17; earliest next accept is T+18.
- Progressive outputs, each a sign-applied truncated magnitude (negated in two's complement when sign=1):
  - q0_3_out = ±mag[15:12], registered at edge T+5. q0_3_valid is high for that single cycle only.
  - q0_7_out = ±mag[15:8], registered at edge T+9. q0_7_valid is high for that single cycle only.
  - q0_15_out = ±mag[15:0], registered at edge T+17 together with overflow and div_by_zero. q0_15_valid is high for that single cycle only.
- Data outputs hold their values until the next update or reset.
- Busy behaviour: valid_in while not IDLE is ignored. Inputs are sampled only on the accept edge; later changes to dividend/divisor have no effect.
- Sign when mag==0: the result is 0 regardless of sign. There is no negative zero.

Test Plan:
1. N=0x10000000 (0.25), D=0x4000 (0.5) -> q0_3_out=0x4 @T+5, q0_7_out=0x40 @T+9, q0_15_out=0x4000 @T+17; overflow=0, div_by_zero=0; ready_out low during T+1..T+17.
2. N=0xF0000000 (-0.25), D=0x4000 -> q0_3_out=0xC, q0_7_out=0xC0, q0_15_out=0xC000.
3. N=0x20000000, D=0x4000 (quotient 1.0) -> q0_15_out=0x7FFF, q0_3_out=0x7, overflow=1. Then N=0xE0000000, D=0x4000 -> q0_15_out=0x8000, q0_3_out=0x8, overflow=1.
4. N=0x00001234, D=0 -> q0_15_out=0x7FFF, div_by_zero=1, overflow=0. N=0xFFFFEDCC, D=0 -> q0_15_out=0x8000, div_by_zero=1.
5. Truncation: N=100, D=3 -> q0_3_out=0x0, q0_7_out=0x00, q0_15_out=0x0021. N=-100 (0xFFFFFF9C), D=3 -> q0_15_out=0xFFDF.
6. Robustness:
   - Pulse valid_in with new operands at T+3: ignored, and the result of the first operation is unchanged.
   - Assert rst at T+7: all outputs 0 and ready_out=1 next cycle; no q0_7_valid or q0_15_valid pulse.
   - A new request accepted after reset completes normally.
